// File: rtl/iob_wb_mem_responder_pkg.sv
// Shared definitions for the Wishbone memory responder and its benches.
//   - CTI / BTE codes seen on wb_cti_i / wb_bte_i
//   - FSM state encoding of the responder
package iob_wb_mem_responder_pkg;

    localparam logic [2:0] CtiClassic = 3'b000;
    localparam logic [2:0] CtiIncr    = 3'b010;
    localparam logic [2:0] CtiEob     = 3'b111;
    localparam logic [1:0] BteLinear  = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAck,
        StBurst,
        StErr
    } state_e;

endpackage

// File: rtl/iob_wb_mem_responder_ram.sv
// Single-port RAM, 2**AddrW words of DataW bits, per-byte write enable, registered read.
// Read-first: a read and write to the same word in one cycle returns the old data.
// Contents are not reset.
// Ports:
//   clk_i    clock
//   addr_i   word address
//   we_i     write enable (qualified per byte by be_i)
//   be_i     byte enables
//   wdata_i  write data
//   rdata_o  read data, one cycle after addr_i
module iob_wb_mem_responder_ram #(
    parameter int unsigned AddrW = 12,
    parameter int unsigned DataW = 32
) (
    input  logic               clk_i,
    input  logic [AddrW-1:0]   addr_i,
    input  logic               we_i,
    input  logic [DataW/8-1:0] be_i,
    input  logic [DataW-1:0]   wdata_i,
    output logic [DataW-1:0]   rdata_o
);

    localparam int unsigned Depth = 2 ** AddrW;

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DataW / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_wb_mem_responder.sv
// Wishbone B4 slave memory for the ethmac DMA master port. Serves classic cycles and linear
// incrementing bursts, inserts WAIT_CYCLES wait states before the first ack of each access,
// and answers out-of-window or misaligned addresses with a one-cycle bus error.
// Ports:
//   clk_i, arst_n_i        clock, asynchronous active-low reset
//   wb_adr_i .. wb_bte_i   Wishbone slave inputs (byte address, data, sel, we, cyc, stb, cti, bte)
//   wb_dat_o               read data, valid with wb_ack_o, held otherwise
//   wb_ack_o, wb_err_o     acknowledge / bus error, from registered state masked by cyc & stb
//   ack_cnt_o, err_cnt_o   ack counter (wraps), error counter (saturates)
module iob_wb_mem_responder
    import iob_wb_mem_responder_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 32,
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        MEM_ADDR_W  = 12,
    parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
    parameter int unsigned        WAIT_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic [2:0]            wb_cti_i,
    input  logic [1:0]            wb_bte_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [15:0]           ack_cnt_o,
    output logic [7:0]            err_cnt_o
);

    // Word address with one extra MSB: set once a burst steps past the end of the window.
    typedef logic [MEM_ADDR_W:0] waddr_t;

    state_e            state_q;
    logic [3:0]        wait_q;
    waddr_t            addr_q;
    logic              ack_q;
    logic              err_q;
    logic [15:0]       ack_cnt_q;
    logic [7:0]        err_cnt_q;
    logic [DATA_W-1:0] dat_hold_q;

    logic                  req;
    logic                  addr_ok;
    logic                  burst_go;
    waddr_t                addr_inc;
    logic [MEM_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  ram_we;

    assign req      = wb_cyc_i & wb_stb_i;
    // Window is aligned to its size, so only the bits above the window offset need comparing.
    assign addr_ok  = (wb_adr_i[ADDR_W-1:MEM_ADDR_W+2] == BASE_ADDR[ADDR_W-1:MEM_ADDR_W+2])
                      && (wb_adr_i[1:0] == 2'b00);
    assign burst_go = (wb_cti_i == CtiIncr) && (wb_bte_i == BteLinear);
    assign addr_inc = addr_q + waddr_t'(1);

    assign wb_ack_o  = ack_q & req;
    assign wb_err_o  = err_q & req;
    assign wb_dat_o  = wb_ack_o ? ram_rdata : dat_hold_q;
    assign ram_we    = wb_ack_o & wb_we_i;
    assign ack_cnt_o = ack_cnt_q;
    assign err_cnt_o = err_cnt_q;

    // The RAM has a registered read, so present the address one cycle ahead: the bus address in
    // IDLE (covers zero wait states), the next beat while a read beat is being acked (no bubble),
    // and the current beat otherwise (writes and paused bursts).
    always_comb begin
        ram_addr = addr_q[MEM_ADDR_W-1:0];
        if (state_q == StIdle) begin
            ram_addr = wb_adr_i[MEM_ADDR_W+1:2];
        end else if (wb_ack_o && !wb_we_i) begin
            ram_addr = addr_inc[MEM_ADDR_W-1:0];
        end
    end

    iob_wb_mem_responder_ram #(
        .AddrW (MEM_ADDR_W),
        .DataW (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (wb_sel_i),
        .wdata_i (wb_dat_i),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= StIdle;
            wait_q  <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (!wb_cyc_i) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (wb_stb_i) begin
                        if (addr_ok) begin
                            addr_q <= {1'b0, wb_adr_i[MEM_ADDR_W+1:2]};
                            wait_q <= 4'(WAIT_CYCLES);
                            if (WAIT_CYCLES == 0) begin
                                state_q <= StAck;
                                ack_q   <= 1'b1;
                            end else begin
                                state_q <= StWait;
                            end
                        end else begin
                            state_q <= StErr;
                            err_q   <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        state_q <= StAck;
                        ack_q   <= 1'b1;
                    end
                end
                StAck: begin
                    if (wb_stb_i) begin
                        if (burst_go) begin
                            state_q <= StBurst;
                            addr_q  <= addr_inc;
                            ack_q   <= ~addr_inc[MEM_ADDR_W];
                            err_q   <= addr_inc[MEM_ADDR_W];
                        end else begin
                            state_q <= StIdle;
                            ack_q   <= 1'b0;
                        end
                    end
                end
                StBurst: begin
                    if (wb_stb_i) begin
                        // An error beat or any non-incrementing cycle type closes the burst.
                        if (err_q || (wb_cti_i != CtiIncr)) begin
                            state_q <= StIdle;
                            ack_q   <= 1'b0;
                            err_q   <= 1'b0;
                        end else begin
                            addr_q <= addr_inc;
                            ack_q  <= ~addr_inc[MEM_ADDR_W];
                            err_q  <= addr_inc[MEM_ADDR_W];
                        end
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ack_cnt_q  <= '0;
            err_cnt_q  <= '0;
            dat_hold_q <= '0;
        end else begin
            if (wb_ack_o) begin
                ack_cnt_q  <= ack_cnt_q + 16'd1;
                dat_hold_q <= ram_rdata;
            end
            if (wb_err_o && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_iob_wb_mem_responder.sv
// Self-checking bench for iob_wb_mem_responder (WAIT_CYCLES=2, BASE_ADDR=0, MEM_ADDR_W=12).
// Directed cases followed by random classic/burst traffic checked against a word-array model.
module tb_iob_wb_mem_responder;
    import iob_wb_mem_responder_pkg::*;

    localparam int unsigned Wait   = 2;
    localparam logic [31:0] WinEnd = 32'h0000_4000;

    logic        clk_i = 1'b0;
    logic        arst_n_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [15:0] ack_cnt_o;
    logic [7:0]  err_cnt_o;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: word contents plus which bytes hold a known value.
    logic [31:0] mem_m   [4096];
    logic [3:0]  known_m [4096];
    int unsigned acks_m;
    int unsigned errs_m;
    logic [31:0] last_rd;

    always #5 clk_i = ~clk_i;

    iob_wb_mem_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MEM_ADDR_W  (12),
        .BASE_ADDR   (32'h0),
        .WAIT_CYCLES (Wait)
    ) dut (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cti_i  (wb_cti_i),
        .wb_bte_i  (wb_bte_i),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .ack_cnt_o (ack_cnt_o),
        .err_cnt_o (err_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    // One classic access (n=1, burst=0) or a linear burst of n beats starting at addr.
    // sel0 == 0 selects random byte enables; rnd selects random data, else wd0+k.
    // After beat pause_at the strobe is dropped for pause_len cycles.
    task automatic xfer(input logic [31:0] addr, input int n, input bit we, input bit burst,
                        input logic [31:0] wd0, input logic [3:0] sel0, input bit rnd,
                        input int pause_at, input int pause_len);
        logic [31:0] a, wd, km, dat;
        logic [3:0]  sel;
        int          lat, exp_lat, w;
        bit          exp_err, got_ack, got_err;
        for (int k = 0; k < n; k++) begin
            a   = addr + 32'(4 * k);
            wd  = rnd ? $urandom : wd0 + 32'(k);
            sel = (sel0 == 4'h0) ? 4'($urandom_range(1, 15)) : sel0;
            wb_cyc_i = 1'b1;
            wb_stb_i = 1'b1;
            wb_we_i  = we;
            wb_adr_i = a;
            wb_dat_i = wd;
            wb_sel_i = sel;
            wb_cti_i = !burst ? CtiClassic : ((k == n - 1) ? CtiEob : CtiIncr);
            wb_bte_i = BteLinear;
            exp_err  = (a >= WinEnd) || (a[1:0] != 2'b00);
            exp_lat  = (k != 0) ? 0 : (exp_err ? 1 : int'(Wait) + 1);
            lat = 0;
            @(negedge clk_i);
            while (!(wb_ack_o || wb_err_o) && lat < 20) begin
                @(negedge clk_i);
                lat++;
            end
            got_ack = wb_ack_o;
            got_err = wb_err_o;
            dat     = wb_dat_o;
            check_eq("latency", 32'(lat), 32'(exp_lat));
            check_eq("ack", 32'(got_ack), 32'(!exp_err));
            check_eq("err", 32'(got_err), 32'(exp_err));
            w = int'(a[13:2]);
            if (exp_err) begin
                if (errs_m < 255) errs_m++;
            end else begin
                acks_m++;
                if (we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) begin
                            mem_m[w][b*8 +: 8] = wd[b*8 +: 8];
                            known_m[w][b]      = 1'b1;
                        end
                    end
                end else begin
                    km = byte_mask(known_m[w]);
                    check_eq("rdata", dat & km, mem_m[w] & km);
                    last_rd = dat;
                end
            end
            @(posedge clk_i);
            #1;
            if (exp_err || lat >= 20) break;
            if (burst && k == pause_at && k < n - 1) begin
                wb_stb_i = 1'b0;
                repeat (pause_len) begin
                    @(negedge clk_i);
                    check_eq("pause_ack", 32'(wb_ack_o), 32'd0);
                    @(posedge clk_i);
                    #1;
                end
            end
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk_i);
        check_eq("ack_cnt", 32'(ack_cnt_o), acks_m & 32'hFFFF);
        check_eq("err_cnt", 32'(err_cnt_o), errs_m);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int          lat;
        int unsigned r;
        int          n;
        logic [31:0] a;
        bit          we;
        logic [15:0] c0;

        for (int i = 0; i < 4096; i++) begin
            mem_m[i]   = '0;
            known_m[i] = '0;
        end
        acks_m   = 0;
        errs_m   = 0;
        last_rd  = '0;
        arst_n_i = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_cti_i = CtiClassic;
        wb_bte_i = BteLinear;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
        check_eq("rst_err", 32'(wb_err_o), 32'd0);
        check_eq("rst_dat", wb_dat_o, 32'd0);
        check_eq("rst_ack_cnt", 32'(ack_cnt_o), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        arst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill the low 64 words with one long write burst.
        xfer(32'h0, 64, 1'b1, 1'b1, 32'h0, 4'hF, 1'b1, -1, 0);

        // Classic write then read back.
        xfer(32'h10, 1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'hF, 1'b0, -1, 0);
        xfer(32'h10, 1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b0, -1, 0);
        check_eq("t1_rd", last_rd, 32'hDEAD_BEEF);

        // Single byte lane write.
        xfer(32'h20, 1, 1'b1, 1'b0, 32'h1122_3344, 4'hF, 1'b0, -1, 0);
        xfer(32'h20, 1, 1'b1, 1'b0, 32'h0000_00AA, 4'h1, 1'b0, -1, 0);
        xfer(32'h20, 1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b0, -1, 0);
        check_eq("t2_rd", last_rd, 32'h1122_33AA);

        // Read burst of 1,2,3,4.
        xfer(32'h100, 4, 1'b1, 1'b1, 32'd1, 4'hF, 1'b0, -1, 0);
        c0 = ack_cnt_o;
        xfer(32'h100, 4, 1'b0, 1'b1, 32'h0, 4'hF, 1'b0, -1, 0);
        check_eq("t3_ack_delta", 32'(ack_cnt_o - c0), 32'd4);
        check_eq("t3_last", last_rd, 32'd4);

        // Paused read burst: strobe low 3 cycles after beat 2.
        xfer(32'h100, 4, 1'b0, 1'b1, 32'h0, 4'hF, 1'b0, 1, 3);
        check_eq("t4_last", last_rd, 32'd4);

        // Out-of-window and misaligned writes, then a burst running off the window end.
        xfer(32'h4000, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, -1, 0);
        xfer(32'h0002, 1, 1'b1, 1'b0, 32'hCAFE_F00D, 4'hF, 1'b0, -1, 0);
        check_eq("t5_err_cnt", 32'(err_cnt_o), 32'd2);
        xfer(32'h0, 1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b0, -1, 0);
        xfer(32'h3FFC, 2, 1'b1, 1'b1, 32'h7777_0000, 4'hF, 1'b0, -1, 0);
        xfer(32'h3FFC, 1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b0, -1, 0);
        check_eq("t5_edge_rd", last_rd, 32'h7777_0000);

        // Cycle dropped during the wait states of a write.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 32'h40;
        wb_dat_i = 32'h5555_AAAA;
        wb_sel_i = 4'hF;
        wb_cti_i = CtiClassic;
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            check_eq("t6_no_resp", 32'(wb_ack_o | wb_err_o), 32'd0);
            @(posedge clk_i);
            #1;
        end
        xfer(32'h40, 1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b0, -1, 0);

        // Reset asserted in the middle of a read burst.
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 32'h100;
        wb_cti_i = CtiIncr;
        wb_bte_i = BteLinear;
        lat = 0;
        @(negedge clk_i);
        while (!wb_ack_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
        check_eq("t6_lat", 32'(lat), 32'(Wait + 1));
        check_eq("t6_beat1", wb_dat_o, mem_m[64]);
        @(posedge clk_i);
        #1;
        wb_adr_i = 32'h104;
        @(negedge clk_i);
        check_eq("t6_beat2_ack", 32'(wb_ack_o), 32'd1);
        check_eq("t6_beat2", wb_dat_o, mem_m[65]);
        #2;
        arst_n_i = 1'b0;
        #1;
        acks_m = 0;
        errs_m = 0;
        check_eq("t6_rst_ack", 32'(wb_ack_o), 32'd0);
        check_eq("t6_rst_err", 32'(wb_err_o), 32'd0);
        check_eq("t6_rst_dat", wb_dat_o, 32'd0);
        check_eq("t6_rst_ack_cnt", 32'(ack_cnt_o), 32'd0);
        check_eq("t6_rst_err_cnt", 32'(err_cnt_o), 32'd0);
        @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        arst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        xfer(32'h100, 1, 1'b0, 1'b0, 32'h0, 4'hF, 1'b0, -1, 0);
        check_eq("t6_after_rst", last_rd, 32'd1);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            we = 1'($urandom_range(0, 1));
            case (r)
                0, 1, 2, 3: begin
                    xfer(32'($urandom_range(0, 63)) * 4, 1, we, 1'b0, 32'h0, 4'h0, 1'b1, -1, 0);
                end
                4, 5, 6: begin
                    n = int'($urandom_range(1, 6));
                    xfer(32'($urandom_range(0, 56)) * 4, n, we, 1'b1, 32'h0, 4'h0, 1'b1,
                         int'($urandom_range(0, n)), int'($urandom_range(1, 3)));
                end
                7: begin
                    if ($urandom_range(0, 1) == 0) a = 32'h4000 + 32'($urandom_range(0, 255)) * 4;
                    else a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
                    xfer(a, 1, we, 1'b0, 32'h0, 4'h0, 1'b1, -1, 0);
                end
                8: begin
                    n = int'($urandom_range(2, 5));
                    xfer(WinEnd - 32'($urandom_range(1, 3)) * 4, n, we, 1'b1, 32'h0, 4'h0, 1'b1,
                         int'($urandom_range(0, n)), int'($urandom_range(1, 2)));
                end
                default: begin
                    xfer(WinEnd - 32'($urandom_range(1, 4)) * 4, 1, we, 1'b0, 32'h0, 4'h0, 1'b1,
                         -1, 0);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
